// File: rtl/branch.sv
// branch -- RV32I branch comparator.
//
// Compares two XLEN-bit operands combinationally and provides:
//   dataA, dataB : operands (rs1, rs2)
//   BrUn         : 1 = unsigned compare, 0 = two's-complement signed compare
//   BrEq         : dataA == dataB (combinational, independent of clk)
//   BrLt         : dataA <  dataB under BrUn (combinational, never 1 with BrEq)
//   clk, rst     : clock (rising edge) and asynchronous active-high reset
//   BrEq_r       : BrEq registered on clk
//   BrLt_r       : BrLt registered on clk
//   cmp_err      : sticky self-check mismatch flag, cleared only by rst
//
// Build option: define BRANCH_SELFCHECK_EN to build an independent
// relational-operator comparator that is checked against the primary path
// on every clock edge. Without it, cmp_err is tied to 0.
module branch #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] dataA,
    input  logic [XLEN-1:0] dataB,
    input  logic            BrUn,
    output logic            BrEq,
    output logic            BrLt,
    input  logic            clk,
    input  logic            rst,
    output logic            BrEq_r,
    output logic            BrLt_r,
    output logic            cmp_err
);

    // Zero-extended subtraction: bit XLEN is the borrow-out.
    logic [XLEN:0] diff;
    logic          borrow;
    logic          sign_diff;
    logic          lt_raw;

    always_comb begin
        diff      = {1'b0, dataA} - {1'b0, dataB};
        borrow    = diff[XLEN];
        sign_diff = dataA[XLEN-1] ^ dataB[XLEN-1];
        // A zero difference is exactly operand equality.
        BrEq      = (diff[XLEN-1:0] == '0);
        // Signed: differing signs decide by A's sign; equal signs reduce to
        // the unsigned borrow.
        lt_raw    = (!BrUn && sign_diff) ? dataA[XLEN-1] : borrow;
        BrLt      = lt_raw && !BrEq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BrEq_r <= 1'b0;
            BrLt_r <= 1'b0;
        end else begin
            BrEq_r <= BrEq;
            BrLt_r <= BrLt;
        end
    end

`ifdef BRANCH_SELFCHECK_EN
    logic ref_eq;
    logic ref_lt;

    always_comb begin
        ref_eq = (dataA == dataB);
        ref_lt = BrUn ? (dataA < dataB) : ($signed(dataA) < $signed(dataB));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_err <= 1'b0;
        end else if ((ref_eq != BrEq) || (ref_lt != BrLt)) begin
            cmp_err <= 1'b1;
        end
    end
`else
    assign cmp_err = 1'b0;
`endif

endmodule

// File: tb/tb_branch.sv
// tb_branch -- scoreboard bench for the branch comparator.
// Stimulus pushes expected combinational and registered flags into queues;
// independent monitor processes pop and compare against the DUT.
module tb_branch;

    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        BrUn;
    logic        BrEq;
    logic        BrLt;
    logic        clk;
    logic        rst;
    logic        BrEq_r;
    logic        BrLt_r;
    logic        cmp_err;

    branch #(.XLEN(32)) dut (
        .dataA  (dataA),
        .dataB  (dataB),
        .BrUn   (BrUn),
        .BrEq   (BrEq),
        .BrLt   (BrLt),
        .clk    (clk),
        .rst    (rst),
        .BrEq_r (BrEq_r),
        .BrLt_r (BrLt_r),
        .cmp_err(cmp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          un;
        bit          eq;
        bit          lt;
    } comb_t;

    typedef struct {
        int due;
        bit eq;
        bit lt;
    } reg_t;

    comb_t comb_q[$];
    reg_t  reg_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: map each operand to its mathematical integer value under
    // the selected interpretation, then compare integers.
    function automatic longint value_of(logic [31:0] x, bit un);
        if (un) return longint'({32'b0, x});
        return longint'($signed(x));
    endfunction

    // Combinational monitor.
    initial begin
        comb_t e;
        forever begin
            wait (comb_q.size() != 0);
            e = comb_q.pop_front();
            chk($sformatf("BrEq a=%h b=%h un=%0d", e.a, e.b, e.un), {31'b0, BrEq}, {31'b0, e.eq});
            chk($sformatf("BrLt a=%h b=%h un=%0d", e.a, e.b, e.un), {31'b0, BrLt}, {31'b0, e.lt});
            chk("eq_lt_exclusive", {31'b0, BrEq & BrLt}, 32'd0);
        end
    end

    // Registered monitor: compare entries whose capture edge has passed.
    initial begin
        reg_t r;
        forever begin
            @(negedge clk);
            while (reg_q.size() != 0 && reg_q[0].due <= cyc) begin
                r = reg_q.pop_front();
                chk("BrEq_r", {31'b0, BrEq_r}, {31'b0, r.eq});
                chk("BrLt_r", {31'b0, BrLt_r}, {31'b0, r.lt});
            end
        end
    end

    task automatic expect_now(logic [31:0] a, logic [31:0] b, bit un);
        comb_t c;
        reg_t  r;
        c.a  = a;
        c.b  = b;
        c.un = un;
        c.eq = (value_of(a, un) == value_of(b, un));
        c.lt = (value_of(a, un) <  value_of(b, un));
        comb_q.push_back(c);
        r.due = cyc + 1;
        r.eq  = c.eq;
        r.lt  = c.lt;
        reg_q.push_back(r);
    endtask

    // Drive just after a posedge, settle 1 unit with no clock, then record.
    task automatic apply(logic [31:0] a, logic [31:0] b, bit un);
        @(posedge clk);
        #1;
        dataA = a;
        dataB = b;
        BrUn  = un;
        #1;
        expect_now(a, b, un);
    endtask

    task automatic drain();
        int budget = 20;
        while ((comb_q.size() != 0 || reg_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        chk("queues_drained", comb_q.size() + reg_q.size(), 32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners [6];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'h7FFF_FFFF;
        corners[4] = 32'h0000_0001;
        corners[5] = 32'h8000_0001;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] ra;
        dataA = '0;
        dataB = '0;
        BrUn  = 1'b0;
        rst   = 1'b1;
        #12;
        chk("reset_BrEq_r", {31'b0, BrEq_r}, 32'd0);
        chk("reset_BrLt_r", {31'b0, BrLt_r}, 32'd0);
        chk("reset_cmp_err", {31'b0, cmp_err}, 32'd0);
        // Combinational flags are live during reset: 0 == 0.
        chk("reset_live_BrEq", {31'b0, BrEq}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors.
        apply(32'd5, 32'd10, 1'b0);
        apply(32'd10, 32'd5, 1'b0);
        apply(32'd5, 32'd5, 1'b0);
        apply(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        apply(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        apply(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        apply(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        apply(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        apply(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        apply(32'h8000_0000, 32'h8000_0000, 1'b0);
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        apply(32'h0000_0000, 32'h0000_0000, 1'b1);
        drain();

        // Asynchronous reset after a cycle that registered BrEq_r=1.
        apply(32'h1234_5678, 32'h1234_5678, 1'b0);
        drain();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_BrEq_r", {31'b0, BrEq_r}, 32'd0);
        chk("async_rst_BrLt_r", {31'b0, BrLt_r}, 32'd0);
        chk("rst_live_BrEq", {31'b0, BrEq}, 32'd1);
        #1;
        rst = 1'b0;
        // The next posedge captures the current (equal) flags.
        expect_now(dataA, dataB, BrUn);
        drain();

        // Randomized vectors, one per clock.
        for (int i = 0; i < 1000; i++) begin
            ra = rand_operand();
            if ($urandom_range(0, 7) == 0) apply(ra, ra, 1'($urandom_range(0, 1)));
            else apply(ra, rand_operand(), 1'($urandom_range(0, 1)));
        end
        drain();
        chk("cmp_err_final", {31'b0, cmp_err}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
